alu_mul_seq: RTL

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-and-add multiplier (low 16 bits of a*b) built around a single alu.
// Optional ALU_MUL_SEQ_EARLY_EXIT_EN ends the run once no multiplier bits remain.

module alu (
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] d_out
);
  logic [15:0] x1, x2, y1, y2, o;

  always_comb begin
    x1    = zx ? 16'h0000 : x;
    x2    = nx ? ~x1 : x1;
    y1    = zy ? 16'h0000 : y;
    y2    = ny ? ~y1 : y1;
    o     = f ? (x2 + y2) : (x2 & y2);
    d_out = no ? ~o : o;
  end
endmodule

module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        zr,
  output logic        ng
);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] product_q, product_d;
  logic        zr_q, zr_d;
  logic        ng_q, ng_d;
  logic [15:0] alu_out;
  logic        last_shift;

  // Configured as a plain adder: acc + mcand.
  alu u_alu (
    .zx    (1'b0),
    .nx    (1'b0),
    .zy    (1'b0),
    .ny    (1'b0),
    .f     (1'b1),
    .no    (1'b0),
    .x     (acc_q),
    .y     (mcand_q),
    .d_out (alu_out)
  );

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  // Nothing left to add once the bits above the one just consumed are all zero.
  assign last_shift = (count_q == 4'd15) || (mplier_q[15:1] == 15'd0);
`else
  assign last_shift = (count_q == 4'd15);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 16'h0000;
      mcand_q   <= 16'h0000;
      mplier_q  <= 16'h0000;
      count_q   <= 4'd0;
      product_q <= 16'h0000;
      zr_q      <= 1'b1;
      ng_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last_shift ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    zr_d      = zr_q;
    ng_d      = ng_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = 16'h0000;
          mcand_d  = a;
          mplier_d = b;
          count_d  = 4'd0;
        end
      end
      ADD: begin
        if (mplier_q[0]) acc_d = alu_out;
      end
      SHIFT: begin
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        count_d  = count_q + 4'd1;
      end
      DONE: begin
        product_d = acc_q;
        zr_d      = (acc_q == 16'h0000);
        ng_d      = acc_q[15];
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign product = product_q;
  assign zr      = zr_q;
  assign ng      = ng_q;
endmodule
